// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads a 1-cycle synchronous instruction
// memory, parks returned words across decode stalls, and feeds the IF/ID register.
module pc_fetch_stage #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned PC_STEP  = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               pcsrc,
    input  logic [ADDR_W-1:0]  target,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ifid_valid,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [ADDR_W-1:0]  ifid_pc_plus,
    output logic [INSTR_W-1:0] ifid_instr
);

    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP - ADDR_W'(1));
    localparam logic [ADDR_W-1:0] PC_INIT    = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0]  pc;
    logic               inflight_valid;
    logic [ADDR_W-1:0]  inflight_pc;
    logic               hold_valid;
    logic [ADDR_W-1:0]  hold_pc;
    logic [INSTR_W-1:0] hold_instr;

    always_comb begin
        imem_en      = !rst && !pcsrc && !stall;
        imem_addr    = pc;
        ifid_pc_plus = ifid_pc + STEP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= PC_INIT;
            inflight_valid <= 1'b0;
            inflight_pc    <= '0;
            hold_valid     <= 1'b0;
            hold_pc        <= '0;
            hold_instr     <= '0;
            ifid_valid     <= 1'b0;
            ifid_pc        <= '0;
            ifid_instr     <= '0;
        end else if (pcsrc) begin
            // Redirect flushes everything in flight; IF/ID payload is left as-is.
            pc             <= target & ALIGN_MASK;
            inflight_valid <= 1'b0;
            hold_valid     <= 1'b0;
            ifid_valid     <= 1'b0;
        end else if (stall) begin
            inflight_valid <= 1'b0;
            if (inflight_valid && !hold_valid) begin
                hold_valid <= 1'b1;
                hold_pc    <= inflight_pc;
                hold_instr <= imem_rdata;
            end
        end else begin
            pc             <= pc + STEP;
            inflight_valid <= 1'b1;
            inflight_pc    <= pc;
            // A parked word is older than anything in flight, so it drains first.
            if (hold_valid) begin
                ifid_valid <= 1'b1;
                ifid_pc    <= hold_pc;
                ifid_instr <= hold_instr;
                hold_valid <= 1'b0;
            end else begin
                ifid_valid <= inflight_valid;
                ifid_pc    <= inflight_pc;
                ifid_instr <= imem_rdata;
            end
        end
    end

endmodule
